// File: rtl/temp_register_file.sv
// Multi-beat, multi-entry temporary register file: assembles WORD_WIDTH words from BUS_WIDTH beats
// (LS beat first) and commits them into DEPTH entries. Optional write-to-read bypass: TEMP_REG_BYPASS_EN.
module temp_register_file #(
  parameter int BUS_WIDTH  = 4,
  parameter int WORD_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BUS_WIDTH-1:0]      data_bus,
  input  logic                      temp_register_enable,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic                      load_abort,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr,
  output logic [WORD_WIDTH-1:0]     B,
  output logic                      busy,
  output logic                      done,
  output logic [DEPTH-1:0]          valid
);

  localparam int BEATS = WORD_WIDTH / BUS_WIDTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         count_reg, count_next;
  logic [WORD_WIDTH-1:0] asm_reg, asm_next;
  logic [AW-1:0]         addr_reg, addr_next;
  logic [WORD_WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]      valid_reg;
  logic [WORD_WIDTH-1:0] b_reg;
  logic                  done_reg;

  logic [WORD_WIDTH-1:0] merged_word;
  logic [WORD_WIDTH-1:0] read_word;
  logic                  commit;
  logic [AW-1:0]         commit_addr;

  // Partial word with the current beat dropped into the slot selected by the beat counter.
  // In IDLE the counter is always 0, so this also forms the first beat (and the whole word when BEATS==1).
  genvar gi;
  generate
    for (gi = 0; gi < BEATS; gi++) begin : g_merge
      assign merged_word[gi*BUS_WIDTH +: BUS_WIDTH] =
        (count_reg == CW'(gi)) ? data_bus : asm_reg[gi*BUS_WIDTH +: BUS_WIDTH];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    asm_next    = asm_reg;
    addr_next   = addr_reg;
    commit      = 1'b0;
    commit_addr = addr_reg;
    case (state_reg)
      IDLE: begin
        if (temp_register_enable && !load_abort) begin
          asm_next    = merged_word;
          addr_next   = wr_addr;
          commit_addr = wr_addr;
          if (BEATS == 1) begin
            commit = 1'b1;
          end else begin
            count_next = CW'(1);
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (load_abort) begin
          count_next = '0;
          state_next = IDLE;
        end else if (temp_register_enable) begin
          asm_next = merged_word;
          if (count_reg == CW'(BEATS - 1)) begin
            commit     = 1'b1;
            count_next = '0;
            state_next = IDLE;
          end else begin
            count_next = count_reg + CW'(1);
          end
        end
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    read_word = mem_reg[rd_addr];
`ifdef TEMP_REG_BYPASS_EN
    if (commit && (commit_addr == rd_addr)) begin
      read_word = merged_word;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
      asm_reg   <= '0;
      addr_reg  <= '0;
      valid_reg <= '0;
      b_reg     <= '0;
      done_reg  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      asm_reg   <= asm_next;
      addr_reg  <= addr_next;
      b_reg     <= read_word;
      done_reg  <= commit;
      if (commit) begin
        mem_reg[commit_addr]   <= merged_word;
        valid_reg[commit_addr] <= 1'b1;
      end
    end
  end

  assign B     = b_reg;
  assign busy  = (state_reg == COLLECT);
  assign done  = done_reg;
  assign valid = valid_reg;

endmodule

// File: doc/temp_register_file.md
# temp_register_file

Multi-entry temporary register file for the 4-bit datapath. It assembles WORD_WIDTH-bit operands from a narrow BUS_WIDTH-bit data bus over successive strobed beats, least-significant beat first. It commits each completed word into one of DEPTH addressable entries and presents a registered read port B. It generalises the single 4-bit temp register to wide, multi-beat, multi-entry operation with an abort path and an optional same-cycle write-to-read bypass.

## Interface
- BUS_WIDTH, 4, width of data_bus in bits.
- WORD_WIDTH, 8, width of each stored word; must be an integer multiple of BUS_WIDTH.
- DEPTH, 4, number of entries; a power of two, at least 2.
- BEATS (localparam), WORD_WIDTH/BUS_WIDTH, beats per word.
- AW (localparam), $clog2(DEPTH), address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- data_bus  in  BUS_WIDTH  beat data.
- temp_register_enable  in  1  beat strobe; one beat is captured per cycle while high.
- wr_addr  in  AW  destination entry; sampled on the first beat only.
- load_abort  in  1  discards the word in progress.
- rd_addr  in  AW  read address.
- B  out  WORD_WIDTH  registered read data.
- busy  out  1  high while the FSM is in COLLECT.
- done  out  1  one-cycle pulse, high the cycle after a commit.
- valid  out  DEPTH  per-entry written-since-reset flags.

## Operation
- **Reset values:** on rst high at an edge, all entries are 0, valid=0, B=0, busy=0, done=0, beat counter=0, FSM=IDLE.
- **FSM, IDLE:**
  - enable=1 and abort=0: capture data_bus into assembly bits [BUS_WIDTH-1:0] and latch wr_addr.
  - If BEATS==1, commit immediately and stay in IDLE.
  - Otherwise set count=1 and go to COLLECT.
- **FSM, COLLECT:**
  - enable=1: capture data_bus into assembly slice [count*BUS_WIDTH +: BUS_WIDTH] and increment count.
  - On beat BEATS-1: commit, clear count, return to IDLE.
  - enable=0: stall. State, count and partial word are held with no timeout.
- **Commit:** entry[latched addr] takes the assembled word, valid[addr] is set, and done pulses on the next cycle. A commit to an already-valid entry overwrites it.
- **Abort:** load_abort=1 returns the FSM to IDLE, clears count and commits nothing. If abort and enable are both high, abort wins and that beat is dropped. Abort in IDLE has no effect.
- **wr_addr changes mid-word:** ignored; the latched address is used.
- **Read:** every edge, B is loaded with entry[rd_addr]. This happens regardless of the valid bit, so unwritten entries read 0.
- **rst mid-word:** the partial word is lost, no commit occurs, and all entries are cleared.

## Timing
- Write latency: the word is stored at the edge that samples its last beat.
- done is high during the following cycle.
- busy is high from the cycle after the first beat (for BEATS>1) until the cycle after the last beat.
- Read latency: 1 cycle. A change in rd_addr at edge N is visible on B after edge N+1.
- Commit and read of the same entry at the same edge: B gets the old contents unless bypass is compiled in (see Configuration).
- There is no backpressure: a new word may start in the IDLE cycle immediately following a commit.

## Configuration
- Macro: TEMP_REG_BYPASS_EN.
- **Defined:** when a commit occurs at the same edge and the latched address equals rd_addr, B loads the newly assembled word. The value seen on B then equals the value that will be read thereafter.
- **Undefined:** B loads the pre-commit entry contents at that edge; the new value appears one edge later.
- Write behaviour, valid and done are identical in both builds.

## Test plan
- **Reset:** rst for 2 cycles with random bus activity -> B=0, valid=0000, busy=0, done=0.
- **Two-beat load:** BUS_WIDTH=4, WORD_WIDTH=8, wr_addr=2; beats 0xA then 0x5 on consecutive cycles -> entry2=0x5A, valid=0100, done pulses once; rd_addr=2 -> B=0x5A one cycle later.
- **Stall and address change:** beat 0x3, enable low for 3 cycles, wr_addr changed to 1, then beat 0xC -> entry at the original address =0xC3, entry1 unchanged, busy held high during the stall.
- **Abort:** beat 0x7, then abort together with enable and 0x9 -> no commit, valid unchanged, no done pulse. The next two beats 0x1, 0x2 commit 0x21.
- **Same-edge commit/read:** rd_addr held at 3 while 0xEF commits to entry 3, old value 0x00. With TEMP_REG_BYPASS_EN, B=0xEF at the commit edge; without it, B=0x00 then 0xEF.
- **Reset mid-word:** after the first beat, assert rst -> busy=0, no entry written. A subsequent full load commits correctly from beat 0.
